// File: rtl/iterative_muldiv_pkg.sv
// muldiv_pkg: shared types and helpers for the iterative multiply/divide unit.
//   muldiv_op_t    - RV32M funct3 encodings
//   muldiv_state_t - control FSM states
//   is_div / is_signed_a / is_signed_b - decode predicates on an op
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } muldiv_op_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CALC   = 2'd1,
    FINISH = 2'd2
  } muldiv_state_t;

  function automatic logic is_div(muldiv_op_t op);
    return op[2];
  endfunction

  function automatic logic is_signed_a(muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_MULHSU) || (op == OP_DIV) || (op == OP_REM);
  endfunction

  function automatic logic is_signed_b(muldiv_op_t op);
    return (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/iterative_muldiv_if.sv
// iterative_muldiv_if: request/response bundle between the control unit
// (master) and the multiply/divide unit (slave).
//   START/KILL/OP/A/B  - request side, driven by master
//   BUSY/DONE/RESULT/ZERO - status and result, driven by slave
interface iterative_muldiv_if #(
  parameter int N = 32
);
  logic         START;
  logic         KILL;
  logic [2:0]   OP;
  logic [N-1:0] A;
  logic [N-1:0] B;
  logic         BUSY;
  logic         DONE;
  logic [N-1:0] RESULT;
  logic         ZERO;

  modport master (
    output START, KILL, OP, A, B,
    input  BUSY, DONE, RESULT, ZERO
  );

  modport slave (
    input  START, KILL, OP, A, B,
    output BUSY, DONE, RESULT, ZERO
  );
endinterface

// File: rtl/iterative_muldiv.sv
// iterative_muldiv: multi-cycle RV32M multiply/divide unit.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle on
// operand magnitudes; signs are re-applied in FINISH. Divide-by-zero and
// signed overflow skip CALC and finish one cycle after acceptance.
// Ports:
//   CLK  - clock, rising edge
//   RSTN - asynchronous active-low reset
//   bus  - slave side of iterative_muldiv_if (START/KILL/OP/A/B in,
//          BUSY/DONE/RESULT/ZERO out)
module iterative_muldiv
  import muldiv_pkg::*;
#(
  parameter int N = 32
) (
  input logic              CLK,
  input logic              RSTN,
  iterative_muldiv_if.slave bus
);
  localparam int CW = $clog2(N) + 1;

  muldiv_state_t  r_state;
  muldiv_op_t     r_op;
  logic           r_sign_a;
  logic           r_sign_b;
  logic           r_fast;
  logic [N-1:0]   r_fast_val;
  // Multiply: r_mag_a multiplicand, r_mag_b multiplier shifted right.
  // Divide: r_mag_a dividend shifting out MSB-first while quotient bits
  // shift in; r_mag_b divisor; remainder lives in r_acc[2N-1:N].
  logic [N-1:0]   r_mag_a;
  logic [N-1:0]   r_mag_b;
  logic [2*N-1:0] r_acc;
  logic [CW-1:0]  r_cnt;
  logic           r_busy;
  logic           r_done;
  logic [N-1:0]   r_result;

  // Request decode
  muldiv_op_t w_op;
  logic       w_sa, w_sb, w_div_zero, w_ovf, w_fast;
  logic [N-1:0] w_fast_val;

  assign w_op       = muldiv_op_t'(bus.OP);
  assign w_sa       = is_signed_a(w_op) & bus.A[N-1];
  assign w_sb       = is_signed_b(w_op) & bus.B[N-1];
  assign w_div_zero = is_div(w_op) && (bus.B == '0);
  assign w_ovf      = ((w_op == OP_DIV) || (w_op == OP_REM)) &&
                      (bus.A == {1'b1, {(N-1){1'b0}}}) && (&bus.B);
  assign w_fast     = w_div_zero | w_ovf;

  // op[1] separates REM/REMU from DIV/DIVU
  always_comb begin
    w_fast_val = '0;
    if (w_div_zero)
      w_fast_val = w_op[1] ? bus.A : '1;
    else if (w_ovf)
      w_fast_val = w_op[1] ? '0 : bus.A;
  end

  // Multiply step: add multiplicand into the high half, shift right by one
  logic [N:0]     w_mul_sum;
  logic [2*N-1:0] w_mul_acc;
  assign w_mul_sum = {1'b0, r_acc[2*N-1:N]} + {1'b0, (r_mag_b[0] ? r_mag_a : '0)};
  assign w_mul_acc = {w_mul_sum, r_acc[N-1:1]};

  // Restoring divide step on an N+1-bit partial remainder. When the trial
  // subtraction succeeds the true difference is below the divisor, so the
  // low N bits of the modular subtraction are exact.
  logic [N:0]   w_div_shift;
  logic [N-1:0] w_div_diff;
  logic         w_qbit;
  logic [N-1:0] w_rem_next;
  assign w_div_shift = {r_acc[2*N-1:N], r_mag_a[N-1]};
  assign w_qbit      = (w_div_shift >= {1'b0, r_mag_b});
  assign w_div_diff  = w_div_shift[N-1:0] - r_mag_b;
  assign w_rem_next  = w_qbit ? w_div_diff : w_div_shift[N-1:0];

  // Sign correction and result selection
  logic [2*N-1:0] w_prod;
  logic [N-1:0]   w_quot, w_rem, w_final;
  assign w_prod = (r_sign_a ^ r_sign_b) ? -r_acc : r_acc;
  assign w_quot = (r_sign_a ^ r_sign_b) ? -r_mag_a : r_mag_a;
  assign w_rem  = r_sign_a ? -r_acc[2*N-1:N] : r_acc[2*N-1:N];

  always_comb begin
    w_final = w_prod[N-1:0];
    case (r_op)
      OP_MUL:                       w_final = w_prod[N-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: w_final = w_prod[2*N-1:N];
      OP_DIV, OP_DIVU:              w_final = w_quot;
      OP_REM, OP_REMU:              w_final = w_rem;
      default:                      w_final = w_prod[N-1:0];
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      r_state    <= IDLE;
      r_op       <= OP_MUL;
      r_sign_a   <= 1'b0;
      r_sign_b   <= 1'b0;
      r_fast     <= 1'b0;
      r_fast_val <= '0;
      r_mag_a    <= '0;
      r_mag_b    <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
      r_result   <= '0;
    end else begin
      r_done <= 1'b0;
      if (bus.KILL) begin
        r_state <= IDLE;
        r_busy  <= 1'b0;
      end else begin
        case (r_state)
          IDLE: begin
            if (bus.START) begin
              r_op       <= w_op;
              r_sign_a   <= w_sa;
              r_sign_b   <= w_sb;
              r_mag_a    <= w_sa ? -bus.A : bus.A;
              r_mag_b    <= w_sb ? -bus.B : bus.B;
              r_acc      <= '0;
              r_cnt      <= '0;
              r_fast     <= w_fast;
              r_fast_val <= w_fast_val;
              r_busy     <= 1'b1;
              r_state    <= w_fast ? FINISH : CALC;
            end
          end
          CALC: begin
            if (is_div(r_op)) begin
              r_acc[2*N-1:N] <= w_rem_next;
              r_mag_a        <= {r_mag_a[N-2:0], w_qbit};
            end else begin
              r_acc   <= w_mul_acc;
              r_mag_b <= r_mag_b >> 1;
            end
            r_cnt <= r_cnt + 1'b1;
            if (r_cnt == CW'(N - 1))
              r_state <= FINISH;
          end
          FINISH: begin
            r_result <= r_fast ? r_fast_val : w_final;
            r_done   <= 1'b1;
            r_busy   <= 1'b0;
            r_state  <= IDLE;
          end
          default: r_state <= IDLE;
        endcase
      end
    end
  end

  assign bus.BUSY   = r_busy;
  assign bus.DONE   = r_done;
  assign bus.RESULT = r_result;
  assign bus.ZERO   = ~|r_result;

endmodule

// File: tb/tb_iterative_muldiv.sv
module tb_iterative_muldiv;

  localparam int N   = 32;
  localparam int LAT = N + 1;
  localparam int TMO = 100;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  iterative_muldiv_if #(.N(N)) bus ();

  iterative_muldiv #(.N(N)) dut (
    .CLK  (clk),
    .RSTN (rstn),
    .bus  (bus)
  );

  int pass_cnt = 0;
  int check_cnt = 0;

  typedef struct {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
  } vec_t;

  // Reference model: plain 64-bit arithmetic straight from the RV32M rules
  function automatic logic [31:0] ref_model(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    logic signed [63:0] sa, sb, ua, ub, p;
    sa = $signed(a);
    sb = $signed(b);
    ua = {32'd0, a};
    ub = {32'd0, b};
    p  = '0;
    case (op)
      3'd0: begin p = ua * ub; return p[31:0]; end
      3'd1: begin p = sa * sb; return p[63:32]; end
      3'd2: begin p = sa * ub; return p[63:32]; end
      3'd3: begin p = ua * ub; return p[63:32]; end
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return a;
        p = sa / sb; return p[31:0];
      end
      3'd5: begin
        if (b == 0) return 32'hFFFF_FFFF;
        return a / b;
      end
      3'd6: begin
        if (b == 0) return a;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 32'd0;
        p = sa % sb; return p[31:0];
      end
      default: begin
        if (b == 0) return a;
        return a % b;
      end
    endcase
  endfunction

  function automatic int ref_latency(logic [2:0] op, logic [31:0] a, logic [31:0] b);
    if (op[2] && (b == 0)) return 1;
    if ((op == 3'd4 || op == 3'd6) && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return LAT;
  endfunction

  function automatic logic [31:0] rand_operand();
    case ($urandom_range(0, 5))
      0:       return 32'd0;
      1:       return 32'hFFFF_FFFF;
      2:       return 32'h8000_0000;
      3:       return 32'($urandom_range(0, 20));
      default: return $urandom;
    endcase
  endfunction

  // Issue one request from idle and wait for DONE; lat counts edges after accept
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] res, output logic zero, output int lat);
    @(posedge clk); #1;
    bus.START = 1'b1; bus.OP = op; bus.A = a; bus.B = b;
    @(posedge clk); #1;
    bus.START = 1'b0;
    lat = 0;
    while (!bus.DONE && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    res  = bus.RESULT;
    zero = bus.ZERO;
  endtask

  task automatic test_reset();
    check_cnt++; if (bus.BUSY !== 1'b0) $display("FAIL reset_busy got=%b want=0", bus.BUSY); else pass_cnt++;
    check_cnt++; if (bus.DONE !== 1'b0) $display("FAIL reset_done got=%b want=0", bus.DONE); else pass_cnt++;
    check_cnt++; if (bus.RESULT !== 32'd0) $display("FAIL reset_result got=%h want=0", bus.RESULT); else pass_cnt++;
    check_cnt++; if (bus.ZERO !== 1'b1) $display("FAIL reset_zero got=%b want=1", bus.ZERO); else pass_cnt++;
    $display("reset: busy=%b done=%b result=%h zero=%b", bus.BUSY, bus.DONE, bus.RESULT, bus.ZERO);
  endtask

  task automatic test_ops(input string tag, input vec_t v[$]);
    logic [31:0] res, exp;
    logic zero;
    int lat, exp_lat;
    foreach (v[i]) begin
      run_op(v[i].op, v[i].a, v[i].b, res, zero, lat);
      exp = ref_model(v[i].op, v[i].a, v[i].b);
      exp_lat = ref_latency(v[i].op, v[i].a, v[i].b);
      check_cnt++;
      if (res !== exp) $display("FAIL %s_result op=%0d a=%h b=%h got=%h want=%h", tag, v[i].op, v[i].a, v[i].b, res, exp);
      else pass_cnt++;
      check_cnt++;
      if (lat != exp_lat) $display("FAIL %s_latency op=%0d a=%h b=%h got=%0d want=%0d", tag, v[i].op, v[i].a, v[i].b, lat, exp_lat);
      else pass_cnt++;
      check_cnt++;
      if (zero !== (exp == 0)) $display("FAIL %s_zero op=%0d got=%b want=%b", tag, v[i].op, zero, (exp == 0));
      else pass_cnt++;
      $display("%s: op=%0d a=%h b=%h result=%h lat=%0d", tag, v[i].op, v[i].a, v[i].b, res, lat);
    end
  endtask

  task automatic test_directed();
    vec_t v[$];
    v.push_back('{3'd0, 32'd7,          32'hFFFF_FFFD});
    v.push_back('{3'd1, 32'h8000_0000,  32'hFFFF_FFFF});
    v.push_back('{3'd2, 32'h8000_0000,  32'hFFFF_FFFF});
    v.push_back('{3'd3, 32'h8000_0000,  32'hFFFF_FFFF});
    v.push_back('{3'd4, 32'hFFFF_FFF9,  32'd2});
    v.push_back('{3'd6, 32'hFFFF_FFF9,  32'd2});
    v.push_back('{3'd5, 32'd100,        32'd7});
    v.push_back('{3'd7, 32'd100,        32'd7});
    v.push_back('{3'd4, 32'd5,          32'd0});
    v.push_back('{3'd6, 32'd5,          32'd0});
    v.push_back('{3'd4, 32'h8000_0000,  32'hFFFF_FFFF});
    v.push_back('{3'd6, 32'h8000_0000,  32'hFFFF_FFFF});
    test_ops("directed", v);
  endtask

  task automatic test_random();
    vec_t v[$];
    for (int i = 0; i < 40; i++)
      v.push_back('{3'($urandom_range(0, 7)), rand_operand(), rand_operand()});
    test_ops("random", v);
  endtask

  task automatic test_kill();
    logic [31:0] res, old;
    logic zero;
    int lat;
    bit seen;
    run_op(3'd5, 32'd1000, 32'd10, res, zero, lat);
    old = ref_model(3'd5, 32'd1000, 32'd10);
    check_cnt++; if (res !== old) $display("FAIL kill_setup got=%h want=%h", res, old); else pass_cnt++;
    // Start a DIV, then flush it after edge 10
    @(posedge clk); #1;
    bus.START = 1'b1; bus.OP = 3'd4; bus.A = $urandom; bus.B = 32'd3;
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (9) @(posedge clk);
    #1;
    check_cnt++; if (bus.BUSY !== 1'b1) $display("FAIL kill_busy_before got=%b want=1", bus.BUSY); else pass_cnt++;
    bus.KILL = 1'b1;
    @(posedge clk); #1;
    bus.KILL = 1'b0;
    check_cnt++; if (bus.BUSY !== 1'b0) $display("FAIL kill_busy_after got=%b want=0", bus.BUSY); else pass_cnt++;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.DONE) seen = 1'b1;
      @(posedge clk); #1;
    end
    check_cnt++; if (seen) $display("FAIL kill_no_done got=1 want=0"); else pass_cnt++;
    check_cnt++; if (bus.RESULT !== old) $display("FAIL kill_result_held got=%h want=%h", bus.RESULT, old); else pass_cnt++;
    $display("kill: result=%h busy=%b", bus.RESULT, bus.BUSY);
    // KILL together with START in idle discards the request
    bus.START = 1'b1; bus.KILL = 1'b1; bus.OP = 3'd0; bus.A = 32'd3; bus.B = 32'd4;
    @(posedge clk); #1;
    bus.START = 1'b0; bus.KILL = 1'b0;
    check_cnt++; if (bus.BUSY !== 1'b0) $display("FAIL kill_start_busy got=%b want=0", bus.BUSY); else pass_cnt++;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (bus.DONE) seen = 1'b1;
      @(posedge clk); #1;
    end
    check_cnt++; if (seen) $display("FAIL kill_start_no_done got=1 want=0"); else pass_cnt++;
    $display("kill_with_start: busy=%b result=%h", bus.BUSY, bus.RESULT);
  endtask

  task automatic test_start_ignored();
    logic [31:0] a1, b1, exp;
    int lat;
    a1 = $urandom; b1 = $urandom;
    exp = ref_model(3'd3, a1, b1);
    @(posedge clk); #1;
    bus.START = 1'b1; bus.OP = 3'd3; bus.A = a1; bus.B = b1;
    @(posedge clk); #1;
    bus.START = 1'b0;
    lat = 0;
    while (!bus.DONE && lat < TMO) begin
      // A competing request mid-flight must have no effect
      bus.START = (lat == 5);
      bus.OP = 3'd5; bus.A = $urandom; bus.B = 32'd0;
      @(posedge clk); #1;
      lat++;
    end
    bus.START = 1'b0;
    check_cnt++; if (bus.RESULT !== exp) $display("FAIL ignore_result got=%h want=%h", bus.RESULT, exp); else pass_cnt++;
    check_cnt++; if (lat != LAT) $display("FAIL ignore_latency got=%0d want=%0d", lat, LAT); else pass_cnt++;
    $display("start_ignored: result=%h lat=%0d", bus.RESULT, lat);
  endtask

  task automatic test_reset_mid();
    bit seen;
    @(posedge clk); #1;
    bus.START = 1'b1; bus.OP = 3'd0; bus.A = $urandom; bus.B = $urandom;
    @(posedge clk); #1;
    bus.START = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    rstn = 1'b0;
    #1;
    check_cnt++; if (bus.BUSY !== 1'b0) $display("FAIL rstmid_busy got=%b want=0", bus.BUSY); else pass_cnt++;
    check_cnt++; if (bus.DONE !== 1'b0) $display("FAIL rstmid_done got=%b want=0", bus.DONE); else pass_cnt++;
    check_cnt++; if (bus.RESULT !== 32'd0) $display("FAIL rstmid_result got=%h want=0", bus.RESULT); else pass_cnt++;
    check_cnt++; if (bus.ZERO !== 1'b1) $display("FAIL rstmid_zero got=%b want=1", bus.ZERO); else pass_cnt++;
    #1;
    rstn = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(posedge clk); #1;
      if (bus.DONE || bus.BUSY) seen = 1'b1;
    end
    check_cnt++; if (seen) $display("FAIL rstmid_quiet got=1 want=0"); else pass_cnt++;
    $display("reset_mid: busy=%b done=%b result=%h zero=%b", bus.BUSY, bus.DONE, bus.RESULT, bus.ZERO);
  endtask

  task automatic test_back_to_back();
    logic [31:0] a1, b1, a2, b2, exp1, exp2;
    int lat;
    a1 = $urandom; b1 = $urandom; a2 = $urandom; b2 = $urandom;
    exp1 = ref_model(3'd0, a1, b1);
    exp2 = ref_model(3'd0, a2, b2);
    @(posedge clk); #1;
    bus.START = 1'b1; bus.OP = 3'd0; bus.A = a1; bus.B = b1;
    @(posedge clk); #1;
    // START stays high with the second request's operands
    bus.A = a2; bus.B = b2;
    lat = 0;
    while (!bus.DONE && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    check_cnt++; if (bus.RESULT !== exp1) $display("FAIL b2b_result1 got=%h want=%h", bus.RESULT, exp1); else pass_cnt++;
    check_cnt++; if (lat != LAT) $display("FAIL b2b_latency1 got=%0d want=%0d", lat, LAT); else pass_cnt++;
    $display("back_to_back[0]: result=%h lat=%0d", bus.RESULT, lat);
    @(posedge clk); #1;
    bus.START = 1'b0;
    check_cnt++; if (bus.BUSY !== 1'b1) $display("FAIL b2b_no_bubble got=%b want=1", bus.BUSY); else pass_cnt++;
    lat = 0;
    while (!bus.DONE && lat < TMO) begin
      @(posedge clk); #1;
      lat++;
    end
    check_cnt++; if (bus.RESULT !== exp2) $display("FAIL b2b_result2 got=%h want=%h", bus.RESULT, exp2); else pass_cnt++;
    check_cnt++; if (lat != LAT) $display("FAIL b2b_latency2 got=%0d want=%0d", lat, LAT); else pass_cnt++;
    $display("back_to_back[1]: result=%h lat=%0d", bus.RESULT, lat);
  endtask

  initial begin
    bus.START = 1'b0;
    bus.KILL  = 1'b0;
    bus.OP    = 3'd0;
    bus.A     = '0;
    bus.B     = '0;
    rstn      = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    test_reset();
    rstn = 1'b1;
    test_directed();
    test_random();
    test_kill();
    test_start_ignored();
    test_reset_mid();
    test_back_to_back();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
